// File: rtl/addsub_pkg.sv
// Shared encodings for the sequential add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Carry seeded into slice 0: SUB forms A + ~B + 1, carry ops use cin.
  function automatic logic init_carry(op_e op, logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
interface addsub_seq_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  op_e              op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             v;
  logic             z;
  logic             n;

  modport master (
    output in_valid, in1, in2, op, cin, out_ready,
    input  in_ready, out_valid, s, c, v, z, n
  );

  modport slave (
    input  in_valid, in1, in2, op, cin, out_ready,
    output in_ready, out_valid, s, c, v, z, n
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple adder; also exposes the carry into the top bit.
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         c_msb_in
);
  logic [W:0] cy;

  assign cy[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign co       = cy[W];
  assign c_msb_in = cy[W-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock through a shared adder.
// Operands shift right each slice so the adder always sees the low CHUNK bits.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus
);
  localparam int NSL = WIDTH / CHUNK;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  logic [CHUNK-1:0] sl_sum;
  logic             sl_co, sl_cmsb;

  addsub_slice #(.W(CHUNK)) u_slice (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .ci       (carry_q),
    .sum      (sl_sum),
    .co       (sl_co),
    .c_msb_in (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in1;
          b_d     = bus.op[0] ? ~bus.in2 : bus.in2;
          carry_d = init_carry(bus.op, bus.cin);
          cnt_d   = '0;
          z_d     = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result fills from the top; after NSL slices slice 0 sits at bit 0.
        s_d     = (s_q >> CHUNK) | (WIDTH'(sl_sum) << (WIDTH - CHUNK));
        carry_d = sl_co;
        z_d     = z_q & ~(|sl_sum);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_d     = sl_co;
          v_d     = sl_co ^ sl_cmsb;
          n_d     = sl_sum[CHUNK-1];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) & ~rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed + randomized checks of addsub_seq at 16/4, 16/16 and 32/8.
module tb_addsub_seq;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  vld, ordy, ov, ir;
  logic [31:0] a_r, b_r;
  op_e         op_r;
  logic        cin_r;
  logic [35:0] res [3];

  int nvec = 0;
  int nmis = 0;

  addsub_seq_if #(.WIDTH(16)) if0 ();
  addsub_seq_if #(.WIDTH(16)) if1 ();
  addsub_seq_if #(.WIDTH(32)) if2 ();

  assign if0.in_valid = vld[0];  assign if0.out_ready = ordy[0];
  assign if0.in1 = a_r[15:0];    assign if0.in2 = b_r[15:0];
  assign if0.op  = op_r;         assign if0.cin = cin_r;
  assign if1.in_valid = vld[1];  assign if1.out_ready = ordy[1];
  assign if1.in1 = a_r[15:0];    assign if1.in2 = b_r[15:0];
  assign if1.op  = op_r;         assign if1.cin = cin_r;
  assign if2.in_valid = vld[2];  assign if2.out_ready = ordy[2];
  assign if2.in1 = a_r;          assign if2.in2 = b_r;
  assign if2.op  = op_r;         assign if2.cin = cin_r;

  assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign ir = {if2.in_ready,  if1.in_ready,  if0.in_ready};
  assign res[0] = {if0.c, if0.v, if0.z, if0.n, 16'h0, if0.s};
  assign res[1] = {if1.c, if1.v, if1.z, if1.n, 16'h0, if1.s};
  assign res[2] = {if2.c, if2.v, if2.z, if2.n, if2.s};

  addsub_seq #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  addsub_seq #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  addsub_seq #(.WIDTH(32), .CHUNK(8))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, independent of slicing.
  function automatic logic [35:0] model(int w, op_e op, logic [31:0] a, logic [31:0] b, logic cin);
    logic [63:0] m, aa, bb, sum, sv;
    logic        ci, sa, sb, sr;
    m   = (64'd1 << w) - 64'd1;
    aa  = {32'h0, a} & m;
    bb  = ({32'h0, b} ^ (op[0] ? m : 64'h0)) & m;
    ci  = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    sum = aa + bb + {63'h0, ci};
    sv  = sum & m;
    sa  = aa[w-1];
    sb  = bb[w-1];
    sr  = sv[w-1];
    return {sum[w], (sa == sb) && (sr != sa), sv == 64'h0, sr, sv[31:0]};
  endfunction

  task automatic do_op(input int sel, input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, output logic [35:0] r, output int lat);
    int g;
    @(negedge clk);
    a_r = a; b_r = b; op_r = op; cin_r = cin; vld[sel] = 1'b1;
    g = 0;
    while (!ir[sel] && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) check("accept_timeout", 64'(ir[sel]), 64'd1);
    @(posedge clk); #1 vld[sel] = 1'b0;
    lat = 0;
    while (!ov[sel] && lat < 100) begin @(posedge clk); #1 lat++; end
    r = res[sel];
    ordy[sel] = 1'b1;
    @(posedge clk); #1 ordy[sel] = 1'b0;
  endtask

  typedef struct {
    op_e         op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] s;
    logic        c, v, z, n;
  } vec_t;

  vec_t        tbl [11];
  logic [35:0] r;
  int          lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{OP_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{OP_SBB, 16'h0010, 16'h0001, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{OP_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_SBB, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; vld = '0; ordy = '0; a_r = '0; b_r = '0; op_r = OP_ADD; cin_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("reset_state", {27'h0, ov[i], ir[i], res[i]}, 64'h0);
    @(negedge clk) rst = 1'b0;
    #1 check("ready_after_reset", 64'(ir), 64'h7);

    // Directed table on the 16/4 instance
    for (int i = 0; i < 11; i++) begin
      do_op(0, tbl[i].op, {16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].cin, r, lat);
      check($sformatf("vec%0d", i), 64'(r),
            {28'h0, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n, 16'h0, tbl[i].s});
      check($sformatf("lat%0d", i), 64'(lat), 64'd4);
    end

    // Back-pressure: result held, new request ignored while DONE
    @(negedge clk);
    a_r = 32'h3; b_r = 32'h5; op_r = OP_SUB; cin_r = 1'b0; vld[0] = 1'b1;
    @(posedge clk); #1 vld[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 100) begin @(posedge clk); #1 lat++; end
    check("bp_lat", 64'(lat), 64'd4);
    a_r = 32'hAAAA; b_r = 32'h1111; op_r = OP_ADD; vld[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {26'h0, ov[0], ir[0], res[0]},
            {26'h0, 1'b1, 1'b0, 4'b0001, 16'h0, 16'hFFFE});
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1 ordy[0] = 1'b0; vld[0] = 1'b0;
    check("bp_release", {62'h0, ov[0], ir[0]}, 64'h1);
    @(posedge clk); #1;
    check("bp_no_accept", {62'h0, ov[0], ir[0]}, 64'h1);

    // Reset in the middle of slice 2
    @(negedge clk);
    a_r = 32'h00FF; b_r = 32'h0F0F; op_r = OP_ADD; vld[0] = 1'b1;
    @(posedge clk); #1 vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midop_reset", {27'h0, ov[0], res[0]}, 64'h0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("midop_no_result", 64'(ov[0]), 64'h0);
    do_op(0, OP_ADD, 32'h1234, 32'h1111, 1'b0, r, lat);
    check("post_reset_add", 64'(r), {28'h0, 4'b0000, 16'h0, 16'h2345});

    // Random ops on every geometry against the whole-word model
    for (int sel = 0; sel < 3; sel++) begin
      for (int k = 0; k < 25; k++) begin
        op_e         rop;
        logic [31:0] ra, rb;
        logic        rc;
        int          w;
        w   = (sel == 2) ? 32 : 16;
        rop = op_e'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = $urandom;
        rc  = 1'($urandom_range(0, 1));
        if (k < 4) begin ra = '1; rb = (k[0]) ? 32'h0 : 32'h1; end
        if (w == 16) begin ra[31:16] = '0; rb[31:16] = '0; end
        do_op(sel, rop, ra, rb, rc, r, lat);
        check($sformatf("rand%0d_%0d", sel, k), 64'(r), 64'(model(w, rop, ra, rb, rc)));
        check($sformatf("rlat%0d_%0d", sel, k), 64'(lat), (sel == 1) ? 64'd1 : 64'd4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
